// File: rtl/uart_sout_receiver_if.sv
// Byte stream handshake between the serial receiver and its consumer.
// master: receiver drives data/valid; slave: consumer drives ready.
interface uart_sout_receiver_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_sout_receiver.sv
// 8N1 receiver for the SoC UART sout line: 16x oversampling, show-ahead byte FIFO.
// Optional macro UART_SOUT_RECEIVER_PARITY_EN adds an even-parity bit and parity_err pulse.
module uart_sout_receiver #(
  parameter int unsigned CLK_HZ     = 50_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk_50,
  input  logic                 fpga_reset_n,
  input  logic                 uart_sin,
  uart_sout_receiver_if.master rx,
  output logic                 frame_err,
  output logic                 overrun,
`ifdef UART_SOUT_RECEIVER_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 rx_busy
);

  localparam int unsigned DIV    = (CLK_HZ + BAUD * 8) / (BAUD * 16);
  localparam int unsigned TICK_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

  state_t            state, state_n;
  logic              s_meta, s;
  logic [TICK_W-1:0] tick_cnt;
  logic              tick;
  logic              tick_clr_c;
  logic [3:0]        sub_cnt, sub_n;
  logic [2:0]        bit_idx, bit_n;
  logic [7:0]        shift, shift_n;
  logic              push_c;
  logic              frame_err_n;
`ifdef UART_SOUT_RECEIVER_PARITY_EN
  logic              par_bad, par_bad_n;
  logic              parity_err_n;
`endif

  logic [7:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_ptr_n;
  logic [CNT_W-1:0]  count, count_n;
  logic              pop_c, full_c, wr_en_c, ovr_c;
  logic [7:0]        head_n;

  // Two-flop synchronizer; idle-high reset so no false start after reset
  always_ff @(posedge clk_50 or negedge fpga_reset_n) begin
    if (!fpga_reset_n) begin
      s_meta <= 1'b1;
      s      <= 1'b1;
    end else begin
      s_meta <= uart_sin;
      s      <= s_meta;
    end
  end

  // Free-running oversample divider, realigned to the start-bit edge
  always_ff @(posedge clk_50 or negedge fpga_reset_n) begin
    if (!fpga_reset_n)                         tick_cnt <= '0;
    else if (tick_clr_c || tick)               tick_cnt <= '0;
    else                                       tick_cnt <= tick_cnt + TICK_W'(1);
  end

  assign tick = (tick_cnt == TICK_W'(DIV - 1));

  // Decoder state and datapath registers
  always_ff @(posedge clk_50 or negedge fpga_reset_n) begin
    if (!fpga_reset_n) begin
      state      <= IDLE;
      sub_cnt    <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      frame_err  <= 1'b0;
      rx_busy    <= 1'b0;
`ifdef UART_SOUT_RECEIVER_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      sub_cnt    <= sub_n;
      bit_idx    <= bit_n;
      shift      <= shift_n;
      frame_err  <= frame_err_n;
      rx_busy    <= (state_n != IDLE);
`ifdef UART_SOUT_RECEIVER_PARITY_EN
      par_bad    <= par_bad_n;
      parity_err <= parity_err_n;
`endif
    end
  end

  // Next-state and sample decisions
  always_comb begin
    state_n     = state;
    sub_n       = sub_cnt;
    bit_n       = bit_idx;
    shift_n     = shift;
    tick_clr_c  = 1'b0;
    push_c      = 1'b0;
    frame_err_n = 1'b0;
`ifdef UART_SOUT_RECEIVER_PARITY_EN
    par_bad_n    = par_bad;
    parity_err_n = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!s) begin
          state_n    = START;
          tick_clr_c = 1'b1;
          sub_n      = '0;
`ifdef UART_SOUT_RECEIVER_PARITY_EN
          par_bad_n  = 1'b0;
`endif
        end
      end
      START: begin
        if (tick) begin
          if (sub_cnt == 4'd7) begin
            sub_n   = '0;
            bit_n   = '0;
            state_n = s ? IDLE : DATA;
          end else begin
            sub_n = sub_cnt + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (sub_cnt == 4'd15) begin
            sub_n   = '0;
            shift_n = {s, shift[7:1]};
            if (bit_idx == 3'd7) begin
`ifdef UART_SOUT_RECEIVER_PARITY_EN
              state_n = PARITY;
`else
              state_n = STOP;
`endif
            end else begin
              bit_n = bit_idx + 3'd1;
            end
          end else begin
            sub_n = sub_cnt + 4'd1;
          end
        end
      end
`ifdef UART_SOUT_RECEIVER_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (sub_cnt == 4'd15) begin
            sub_n   = '0;
            state_n = STOP;
            if (^{shift, s}) begin
              par_bad_n    = 1'b1;
              parity_err_n = 1'b1;
            end
          end else begin
            sub_n = sub_cnt + 4'd1;
          end
        end
      end
`endif
      STOP: begin
        if (tick) begin
          if (sub_cnt == 4'd15) begin
            sub_n = '0;
            if (s) begin
`ifdef UART_SOUT_RECEIVER_PARITY_EN
              push_c = !par_bad;
`else
              push_c = 1'b1;
`endif
              state_n = IDLE;
            end else begin
              frame_err_n = 1'b1;
              state_n     = WAIT_HIGH;
            end
          end else begin
            sub_n = sub_cnt + 4'd1;
          end
        end
      end
      WAIT_HIGH: begin
        if (s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // FIFO control; when the written slot becomes the head it is forwarded into rx_data
  always_comb begin
    pop_c    = rx.rx_valid && rx.rx_ready;
    full_c   = (count == CNT_W'(FIFO_DEPTH));
    wr_en_c  = push_c && (!full_c || pop_c);
    ovr_c    = push_c && full_c && !pop_c;
    rd_ptr_n = pop_c ? rd_ptr + PTR_W'(1) : rd_ptr;
    count_n  = count + CNT_W'(wr_en_c) - CNT_W'(pop_c);
    head_n   = (wr_en_c && (wr_ptr == rd_ptr_n)) ? shift : mem[rd_ptr_n];
  end

  always_ff @(posedge clk_50) begin
    if (wr_en_c) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge clk_50 or negedge fpga_reset_n) begin
    if (!fpga_reset_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      rx.rx_data  <= '0;
      rx.rx_valid <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (wr_en_c) wr_ptr <= wr_ptr + PTR_W'(1);
      rd_ptr      <= rd_ptr_n;
      count       <= count_n;
      rx.rx_data  <= head_n;
      rx.rx_valid <= (count_n != '0);
      overrun     <= ovr_c;
    end
  end

endmodule
